// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch unit: owns the PC, issues reads to a 1-cycle-latency
// instruction memory, and buffers {instruction, PC} pairs in a small FIFO that
// feeds the IF/ID register under a valid/ready handshake. A redirect flushes
// the buffer and the in-flight read, then restarts fetch from a new PC.
module instr_prefetch_unit #(
  parameter int          DEPTH    = 4,
  parameter int          PC_W     = 5,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                       Clk,
  input  logic                       Reset,
  output logic                       Imem_Req,
  output logic [PC_W-1:0]            Imem_Addr,
  input  logic [7:0]                 Imem_Data,
  output logic                       Out_Valid,
  input  logic                       Out_Ready,
  output logic [7:0]                 Out_Instr,
  output logic [PC_W-1:0]            Out_PC,
  input  logic                       Redirect,
  input  logic [PC_W-1:0]            Redirect_PC,
  output logic [$clog2(DEPTH):0]     Fill_Level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0] pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [PC_W-1:0] resp_pc_q, resp_pc_d;
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic [7:0]      instr_mem [DEPTH];
  logic [PC_W-1:0] pc_mem    [DEPTH];

  logic            push;
  logic            pop;
  logic [CW:0]     credits_used;

  // Credit check counts the in-flight read against free space before any
  // same-cycle pop, so a returning response always has a slot waiting.
  always_comb begin
    credits_used = {1'b0, count_q} + (CW+1)'(inflight_q);
    Imem_Req     = !Reset && !Redirect && (credits_used < (CW+1)'(DEPTH));
    Imem_Addr    = pc_q;
    Out_Valid    = (count_q != '0);
    Out_Instr    = Out_Valid ? instr_mem[head_q] : 8'h00;
    Out_PC       = Out_Valid ? pc_mem[head_q]    : '0;
    Fill_Level   = count_q;
    push         = inflight_q && !Redirect;
    pop          = Out_Valid && Out_Ready;
  end

  // Next-state logic for PC, in-flight tracking and FIFO pointers.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which is what would otherwise infer a latch.
    pc_d       = pc_q;
    inflight_d = Imem_Req;
    resp_pc_d  = resp_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    if (Redirect) begin
      pc_d       = Redirect_PC;
      inflight_d = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (Imem_Req) begin
        pc_d      = pc_q + PC_W'(1);
        resp_pc_d = pc_q;
      end
      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers, cleared asynchronously by Reset.
  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    if (Reset) begin
      pc_q       <= PC_W'(RESET_PC);
      inflight_q <= 1'b0;
      resp_pc_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      resp_pc_q  <= resp_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage write at the tail when a response returns.
  always_ff @(posedge Clk) begin
    // NOTE: storage is deliberately not reset; the outputs are masked to zero
    // while the FIFO is empty, so stale contents are never observable.
    if (push) begin
      instr_mem[tail_q] <= Imem_Data;
      pc_mem[tail_q]    <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Self-checking bench for instr_prefetch_unit: a directed table for the
// reset/backpressure start-up, hand-written redirect, wrap and async-reset
// sequences, and randomized traffic against a queue-based reference model.
module tb_instr_prefetch_unit;

  localparam int DEPTH = 4;
  localparam int PC_W  = 5;

  logic            Clk = 1'b0;
  logic            Reset;
  logic            Imem_Req;
  logic [PC_W-1:0] Imem_Addr;
  logic [7:0]      Imem_Data = 8'h00;
  logic            Out_Valid;
  logic            Out_Ready;
  logic [7:0]      Out_Instr;
  logic [PC_W-1:0] Out_PC;
  logic            Redirect;
  logic [PC_W-1:0] Redirect_PC;
  logic [2:0]      Fill_Level;

  int n_checks = 0;
  int n_errors = 0;

  instr_prefetch_unit #(.DEPTH(DEPTH), .PC_W(PC_W), .RESET_PC(0)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Imem_Req    (Imem_Req),
    .Imem_Addr   (Imem_Addr),
    .Imem_Data   (Imem_Data),
    .Out_Valid   (Out_Valid),
    .Out_Ready   (Out_Ready),
    .Out_Instr   (Out_Instr),
    .Out_PC      (Out_PC),
    .Redirect    (Redirect),
    .Redirect_PC (Redirect_PC),
    .Fill_Level  (Fill_Level)
  );

  always #5 Clk = ~Clk;

  // Synchronous instruction memory: word at address a holds a + 8'h40.
  always @(posedge Clk) begin
    if (Imem_Req) Imem_Data <= {3'b000, Imem_Addr} + 8'h40;
  end

  // Reference model: ordered queue of buffered entries plus fetch state.
  typedef struct {
    logic [7:0]      instr;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t          m_q[$];
  logic [PC_W-1:0] m_pc;
  logic            m_inflight;
  logic [PC_W-1:0] m_if_addr;

  typedef struct {
    logic            rdy;
    logic            exp_req;
    logic [PC_W-1:0] exp_addr;
    logic            exp_valid;
    logic [7:0]      exp_instr;
    logic [PC_W-1:0] exp_pc;
    logic [2:0]      exp_fill;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc       = '0;
    m_inflight = 1'b0;
    m_if_addr  = '0;
  endtask

  // Hold reset for two cycles, checking the quiescent outputs, release at a
  // falling edge and leave the bench at that falling edge.
  task automatic do_reset();
    Reset = 1'b1; Out_Ready = 1'b0; Redirect = 1'b0; Redirect_PC = '0;
    @(negedge Clk); @(negedge Clk);
    #1;
    check("rst_req",   Imem_Req,   1'b0);
    check("rst_valid", Out_Valid,  1'b0);
    check("rst_fill",  Fill_Level, 3'd0);
    check("rst_instr", Out_Instr,  8'h00);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
  endtask

  // One cycle: drive inputs, compare against the model, advance the model.
  task automatic step(input logic rdy, input logic redir, input logic [PC_W-1:0] rpc);
    logic   exp_req;
    entry_t e;
    Out_Ready = rdy; Redirect = redir; Redirect_PC = rpc;
    #1;
    exp_req = !redir && ((m_q.size() + (m_inflight ? 1 : 0)) < DEPTH);
    check("imem_req",  Imem_Req,   exp_req);
    check("imem_addr", Imem_Addr,  m_pc);
    check("out_valid", Out_Valid,  m_q.size() > 0);
    check("fill",      Fill_Level, m_q.size());
    check("out_instr", Out_Instr,  (m_q.size() > 0) ? m_q[0].instr : 8'h00);
    check("out_pc",    Out_PC,     (m_q.size() > 0) ? m_q[0].pc : 5'd0);
    check("fill_max",  Fill_Level <= 3'd4, 1'b1);
    @(posedge Clk);
    if (redir) begin
      m_q.delete();
      m_inflight = 1'b0;
      m_pc       = rpc;
    end else begin
      if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
      if (m_inflight) begin
        e.instr = {3'b000, m_if_addr} + 8'h40;
        e.pc    = m_if_addr;
        m_q.push_back(e);
      end
      m_inflight = exp_req;
      m_if_addr  = m_pc;
      if (exp_req) m_pc = m_pc + 5'd1;
    end
    @(negedge Clk);
    Redirect = 1'b0;
  endtask

  vec_t vecs[11];

  initial begin
    // Start-up with Out_Ready=0 until the FIFO is full, then drain.
    //           rdy  req  addr  vld  instr  pc  fill
    vecs[0]  = '{1'b0, 1'b1, 5'd0, 1'b0, 8'h00, 5'd0, 3'd0};
    vecs[1]  = '{1'b0, 1'b1, 5'd1, 1'b0, 8'h00, 5'd0, 3'd0};
    vecs[2]  = '{1'b0, 1'b1, 5'd2, 1'b1, 8'h40, 5'd0, 3'd1};
    vecs[3]  = '{1'b0, 1'b1, 5'd3, 1'b1, 8'h40, 5'd0, 3'd2};
    vecs[4]  = '{1'b0, 1'b0, 5'd4, 1'b1, 8'h40, 5'd0, 3'd3};
    vecs[5]  = '{1'b0, 1'b0, 5'd4, 1'b1, 8'h40, 5'd0, 3'd4};
    vecs[6]  = '{1'b1, 1'b0, 5'd4, 1'b1, 8'h40, 5'd0, 3'd4};
    vecs[7]  = '{1'b1, 1'b1, 5'd4, 1'b1, 8'h41, 5'd1, 3'd3};
    vecs[8]  = '{1'b1, 1'b1, 5'd5, 1'b1, 8'h42, 5'd2, 3'd2};
    vecs[9]  = '{1'b1, 1'b1, 5'd6, 1'b1, 8'h43, 5'd3, 3'd2};
    vecs[10] = '{1'b1, 1'b1, 5'd7, 1'b1, 8'h44, 5'd4, 3'd2};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      Out_Ready = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d_req",   i), Imem_Req,   vecs[i].exp_req);
      check($sformatf("vec%0d_addr",  i), Imem_Addr,  vecs[i].exp_addr);
      check($sformatf("vec%0d_valid", i), Out_Valid,  vecs[i].exp_valid);
      check($sformatf("vec%0d_instr", i), Out_Instr,  vecs[i].exp_instr);
      check($sformatf("vec%0d_pc",    i), Out_PC,     vecs[i].exp_pc);
      check($sformatf("vec%0d_fill",  i), Fill_Level, vecs[i].exp_fill);
      @(negedge Clk);
    end

    // Steady stream, then a one-cycle redirect to 20.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 5'd20);
    #1;
    check("redir_valid_drop", Out_Valid, 1'b0);
    check("redir_first_req",  Imem_Req,  1'b1);
    check("redir_first_addr", Imem_Addr, 5'd20);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    #1;
    check("redir_pc20",    Out_PC,    5'd20);
    check("redir_instr54", Out_Instr, 8'h54);
    step(1'b1, 1'b0, '0);
    #1;
    check("redir_pc21", Out_PC, 5'd21);
    step(1'b1, 1'b0, '0);
    #1;
    check("redir_pc22", Out_PC, 5'd22);

    // PC wrap across 31 -> 0.
    step(1'b1, 1'b1, 5'd31);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    #1;
    check("wrap_pc31",    Out_PC,    5'd31);
    check("wrap_instr5f", Out_Instr, 8'h5F);
    step(1'b1, 1'b0, '0);
    #1;
    check("wrap_pc0",    Out_PC,    5'd0);
    check("wrap_instr40", Out_Instr, 8'h40);
    step(1'b1, 1'b0, '0);
    #1;
    check("wrap_pc1",    Out_PC,    5'd1);
    check("wrap_instr41", Out_Instr, 8'h41);

    // Back-to-back redirects: last one wins, no requests in between.
    step(1'b1, 1'b1, 5'd9);
    step(1'b1, 1'b1, 5'd12);
    #1;
    check("b2b_addr", Imem_Addr, 5'd12);

    // Alternating ready.
    for (int i = 0; i < 40; i++) step(i[0], 1'b0, '0);

    // Randomized traffic with occasional redirects.
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, ($urandom % 20) == 0, PC_W'($urandom));

    // Asynchronous reset mid-stream with three entries buffered.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
    #1;
    check("async_pre_fill", Fill_Level, 3'd3);
    #1;
    Reset = 1'b1;
    #1;
    check("async_valid", Out_Valid,  1'b0);
    check("async_fill",  Fill_Level, 3'd0);
    check("async_req",   Imem_Req,   1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    #1;
    check("async_restart_req",  Imem_Req,  1'b1);
    check("async_restart_addr", Imem_Addr, 5'd0);
    @(negedge Clk);
    model_reset();
    m_pc = 5'd1; m_inflight = 1'b1; m_if_addr = 5'd0;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
